tikhonov_gram: RTL and testbench
================================

Name: tikhonov_gram

Overview:
- Computes the regularised Gram matrix G = H^H·H + λI from a complex channel matrix H (M_ROWS × N_COLS) held in dual-port BRAM.
- Sits between the Hermitian-transpose stage and the matrix-inversion stage.
- Reads two H elements per cycle and MAC-accumulates conj(H[k][i])·H[k][j] over k.
- Adds λ to the diagonal, saturates, and writes each G element to the result BRAM for the inverter.

Parameters:
DATA_WIDTH, 24, signed fixed-point width of real/imag samples (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
FRAC_BITS, 16, fractional bits of input, λ and output
M_ROWS, 8, rows of H (number of accumulation terms)
N_COLS, 4, columns of H; G is N_COLS × N_COLS
BRAM_RD_ADDR_WIDTH, 10, H BRAM address width
BRAM_WR_ADDR_WIDTH, 8, G BRAM address width
LATENCY, 2, H BRAM read latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a computation when idle
lambda_in  in  DATA_WIDTH  regularisation λ (real, same Q format), latched on accepted start
rd_addr_a  out  BRAM_RD_ADDR_WIDTH  port A address = k*N_COLS + i
rd_addr_b  out  BRAM_RD_ADDR_WIDTH  port B address = k*N_COLS + j
a_real_in, a_imag_in  in  DATA_WIDTH each  port A read data H[k][i]
b_real_in, b_imag_in  in  DATA_WIDTH each  port B read data H[k][j]
wr_en  out  1  G write strobe
wr_addr  out  BRAM_WR_ADDR_WIDTH  = i*N_COLS + j
g_real_out, g_imag_out  out  DATA_WIDTH each  G element write data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last write

Behaviour:
- Reset: clk is the clock; rst_n is the asynchronous, active-low reset.
  - All outputs are 0, state is IDLE, and accumulators are cleared.
  - Reset asserted mid-operation aborts immediately with no further writes.
- Start: start is accepted only in IDLE; it latches λ and sets i=j=0. A start seen while busy is ignored.
- States:
  - IDLE -> ISSUE on start.
  - ISSUE (M_ROWS cycles): drive addresses for k=0..M_ROWS-1 and shift a valid bit through a LATENCY-deep delay line.
  - DRAIN (LATENCY+1 cycles): let the final BRAM reads and the product register complete.
  - WRITE (1 cycle): present G element.
  - Then advance j, and i on j wrap, and return to ISSUE. After element (N-1,N-1), go to DONE (1 cycle, done=1) -> IDLE.
- Element cycle count: M_ROWS+LATENCY+2 per element.
  - done is asserted exactly N_COLS²·(M_ROWS+LATENCY+2)+1 cycles after the start cycle.
- MAC pipeline:
  - Products are registered, full 2*DATA_WIDTH precision:
    - re = ar·br + ai·bi
    - im = ar·bi − ai·br
  - Accumulator is ACC = 2*DATA_WIDTH+clog2(M_ROWS)+1 bits signed, cleared at entry to ISSUE.
- Output formation:
  - Each component is acc >>> FRAC_BITS (arithmetic, truncating).
  - On the diagonal (i==j): add sign-extended λ to real; force imag to 0.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Write outputs: wr_en is high only in WRITE. wr_addr and g_* are valid with wr_en and hold their values otherwise.
- Addresses: idle value is 0; only valid addresses are driven during ISSUE.

Optional Feature:
Macro HERM_SYM_EN.
- Defined: only elements with j≥i are computed.
  - For each off-diagonal element, WRITE is followed by WRITE_MIRROR (1 cycle): wr_addr=j*N_COLS+i, g_real same, g_imag negated (saturated).
  - done occurs after the (N-1,N-1) write.
  - Total cycles = [N(N+1)/2·(M_ROWS+LATENCY+2) + N(N−1)/2] + 1.
- Undefined: full N² computation as above. Resulting G contents are identical in both builds.

Test Plan:
1. H[k][c]=1.0 (65536) if k==c else 0, λ=0.25 (16384) -> G diag real=81920 imag=0, off-diag 0, wr_addr 0..15 in order, done at cycle 16·12+1=193.
2. All H=1.0+j1.0, λ=0 -> every G element real=1048576 (16.0), imag=0.
3. H[0][0]=j1.0, H[0][1]=1.0, rest 0 -> G[0][1] imag=−65536, G[1][0] imag=+65536, G[0][0] real=65536.
4. All H real=4.0 -> accumulated 128.0 exceeds range -> all g_real=0x7FFFFF (saturation), imag 0.
5. Second start pulse at cycle 50 of a run -> ignored; write count 16, single done pulse.
6. rst_n low at cycle 30 -> wr_en/busy/done drop to 0 at once, no writes after; new start after release runs a complete, correct computation.

Source files
------------

// File: rtl/tikhonov_gram.sv
// rtl/tikhonov_gram.sv - regularised Gram matrix G = H^H*H + lambda*I from H in dual-port BRAM
// Optional build macro: HERM_SYM_EN (compute upper triangle only, mirror off-diagonal writes)
module tikhonov_gram #(
   parameter int DATA_WIDTH         = 24,
   parameter int FRAC_BITS          = 16,
   parameter int M_ROWS             = 8,
   parameter int N_COLS             = 4,
   parameter int BRAM_RD_ADDR_WIDTH = 10,
   parameter int BRAM_WR_ADDR_WIDTH = 8,
   parameter int LATENCY            = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic signed [DATA_WIDTH-1:0]         lambda_in,
   output logic        [BRAM_RD_ADDR_WIDTH-1:0] rd_addr_a,
   output logic        [BRAM_RD_ADDR_WIDTH-1:0] rd_addr_b,
   input  logic signed [DATA_WIDTH-1:0]         a_real_in,
   input  logic signed [DATA_WIDTH-1:0]         a_imag_in,
   input  logic signed [DATA_WIDTH-1:0]         b_real_in,
   input  logic signed [DATA_WIDTH-1:0]         b_imag_in,
   output logic                                 wr_en,
   output logic        [BRAM_WR_ADDR_WIDTH-1:0] wr_addr,
   output logic signed [DATA_WIDTH-1:0]         g_real_out,
   output logic signed [DATA_WIDTH-1:0]         g_imag_out,
   output logic                                 busy,
   output logic                                 done
);

   localparam int RAW = BRAM_RD_ADDR_WIDTH;
   localparam int WAW = BRAM_WR_ADDR_WIDTH;
   localparam int MW  = 2 * DATA_WIDTH;
   localparam int PW  = 2 * DATA_WIDTH + 1;
   localparam int ACC = 2 * DATA_WIDTH + $clog2(M_ROWS) + 1;
   localparam int CW  = $clog2(M_ROWS + LATENCY + 2) + 1;
   localparam int IW  = $clog2(N_COLS + 1);

   localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_MIRROR, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic        [CW-1:0]         cnt_q, cnt_d;
   logic        [IW-1:0]         i_q, i_d, j_q, j_d;
   logic signed [DATA_WIDTH-1:0] lambda_q, lambda_d;
   logic                         clr_acc;
   logic        [LATENCY-1:0]    vld_q, vld_d;
   logic                         prod_vld_q;
   logic signed [PW-1:0]         pr_q, pi_q, pr_d, pi_d;
   logic signed [ACC-1:0]        acc_re_q, acc_im_q;
   logic        [WAW-1:0]        wr_addr_q;
   logic signed [DATA_WIDTH-1:0] g_real_q, g_imag_q;

   logic signed [MW-1:0]         ar_x, ai_x, br_x, bi_x;
   logic signed [ACC-1:0]        sh_re, sh_im, re_sum;
   logic signed [DATA_WIDTH-1:0] g_re_w, g_im_w, g_im_neg;
   logic                         last_elem, diag;

   function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC-1:0] x);
      if (x > SAT_MAX)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (x < SAT_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                  return x[DATA_WIDTH-1:0];
   endfunction

   assign last_elem = (i_q == IW'(N_COLS-1)) && (j_q == IW'(N_COLS-1));
   assign diag      = (i_q == j_q);

   // State, element counters and latched lambda
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         lambda_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         i_q      <= i_d;
         j_q      <= j_d;
         lambda_q <= lambda_d;
      end
   end

   // Next-state: issue M reads, drain the read/product pipe, write, then step to the next element
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      i_d      = i_q;
      j_d      = j_q;
      lambda_d = lambda_q;
      clr_acc  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lambda_d = lambda_in;
               i_d      = '0;
               j_d      = '0;
               cnt_d    = '0;
               clr_acc  = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cnt_q == CW'(M_ROWS-1)) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(LATENCY)) begin
               cnt_d   = '0;
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef HERM_SYM_EN
         S_WRITE: begin
            if (!diag) begin
               state_d = S_MIRROR;
            end else if (last_elem) begin
               state_d = S_DONE;
            end else begin
               // diagonal, not last: the next element is to its right in the same row
               j_d     = j_q + 1'b1;
               clr_acc = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_MIRROR: begin
            // next row of the upper triangle starts on its diagonal
            if (j_q == IW'(N_COLS-1)) begin
               i_d = i_q + 1'b1;
               j_d = i_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
            clr_acc = 1'b1;
            state_d = S_ISSUE;
         end
`else
         S_WRITE: begin
            if (last_elem) begin
               state_d = S_DONE;
            end else begin
               if (j_q == IW'(N_COLS-1)) begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
               clr_acc = 1'b1;
               state_d = S_ISSUE;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status strobes and BRAM read addresses (zero whenever not issuing)
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      wr_en     = (state_q == S_WRITE) || (state_q == S_MIRROR);
      rd_addr_a = '0;
      rd_addr_b = '0;
      if (state_q == S_ISSUE) begin
         rd_addr_a = RAW'(cnt_q) * RAW'(N_COLS) + RAW'(i_q);
         rd_addr_b = RAW'(cnt_q) * RAW'(N_COLS) + RAW'(j_q);
      end
   end

   // Read-valid delay line matching BRAM latency, plus full-precision conj(a)*b products
   always_comb begin
      vld_d[0] = (state_q == S_ISSUE);
      for (int n = 1; n < LATENCY; n++) begin
         vld_d[n] = vld_q[n-1];
      end
      ar_x = MW'(a_real_in);
      ai_x = MW'(a_imag_in);
      br_x = MW'(b_real_in);
      bi_x = MW'(b_imag_in);
      pr_d = PW'(ar_x * br_x) + PW'(ai_x * bi_x);
      pi_d = PW'(ar_x * bi_x) - PW'(ai_x * br_x);
   end

   // Product register and accumulators; accumulators restart at each element
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q      <= '0;
         prod_vld_q <= 1'b0;
         pr_q       <= '0;
         pi_q       <= '0;
         acc_re_q   <= '0;
         acc_im_q   <= '0;
      end else begin
         vld_q      <= vld_d;
         prod_vld_q <= vld_q[LATENCY-1];
         if (vld_q[LATENCY-1]) begin
            pr_q <= pr_d;
            pi_q <= pi_d;
         end
         if (clr_acc) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
         end else if (prod_vld_q) begin
            acc_re_q <= acc_re_q + ACC'(pr_q);
            acc_im_q <= acc_im_q + ACC'(pi_q);
         end
      end
   end

   // Scale, add lambda on the diagonal, saturate; write data is held between strobes
   always_comb begin
      sh_re      = acc_re_q >>> FRAC_BITS;
      sh_im      = acc_im_q >>> FRAC_BITS;
      re_sum     = diag ? (sh_re + ACC'(lambda_q)) : sh_re;
      g_re_w     = sat(re_sum);
      g_im_w     = diag ? '0 : sat(sh_im);
      g_im_neg   = sat(-ACC'(g_im_w));
      wr_addr    = wr_addr_q;
      g_real_out = g_real_q;
      g_imag_out = g_imag_q;
      if (state_q == S_WRITE) begin
         wr_addr    = WAW'(i_q) * WAW'(N_COLS) + WAW'(j_q);
         g_real_out = g_re_w;
         g_imag_out = g_im_w;
      end else if (state_q == S_MIRROR) begin
         wr_addr    = WAW'(j_q) * WAW'(N_COLS) + WAW'(i_q);
         g_real_out = g_re_w;
         g_imag_out = g_im_neg;
      end
   end

   // Capture the presented write so outputs hold after the strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q <= '0;
         g_real_q  <= '0;
         g_imag_q  <= '0;
      end else if (wr_en) begin
         wr_addr_q <= wr_addr;
         g_real_q  <= g_real_out;
         g_imag_q  <= g_imag_out;
      end
   end

endmodule

// File: tb/tb_tikhonov_gram.sv
// tb/tb_tikhonov_gram.sv - self-checking bench for tikhonov_gram
module tb_tikhonov_gram;

   localparam int N = 4;
   localparam int M = 8;
   localparam int ELEM = M + 2 + 2;
`ifdef HERM_SYM_EN
   localparam int EXP_DONE  = (N*(N+1)/2)*ELEM + N*(N-1)/2 + 1;
   localparam int EXP_ABORT = 3;
`else
   localparam int EXP_DONE  = N*N*ELEM + 1;
   localparam int EXP_ABORT = 2;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic signed [23:0] lambda_in;
   logic        [9:0] rd_addr_a, rd_addr_b;
   logic signed [23:0] a_real_in, a_imag_in, b_real_in, b_imag_in;
   logic              wr_en;
   logic        [7:0] wr_addr;
   logic signed [23:0] g_real_out, g_imag_out;
   logic              busy, done;

   tikhonov_gram dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lambda_in(lambda_in),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .a_real_in(a_real_in), .a_imag_in(a_imag_in),
      .b_real_in(b_real_in), .b_imag_in(b_imag_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .g_real_out(g_real_out), .g_imag_out(g_imag_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // H memory with a two-cycle read pipe on each port
   int mem_re[M*N];
   int mem_im[M*N];
   logic signed [23:0] pa1_re, pa1_im, pb1_re, pb1_im, pa2_re, pa2_im, pb2_re, pb2_im;
   function automatic int idx(input logic [9:0] a);
      return (int'(a) < M*N) ? int'(a) : 0;
   endfunction
   always @(posedge clk) begin
      pa1_re <= 24'(mem_re[idx(rd_addr_a)]);
      pa1_im <= 24'(mem_im[idx(rd_addr_a)]);
      pb1_re <= 24'(mem_re[idx(rd_addr_b)]);
      pb1_im <= 24'(mem_im[idx(rd_addr_b)]);
      pa2_re <= pa1_re; pa2_im <= pa1_im; pb2_re <= pb1_re; pb2_im <= pb1_im;
   end
   assign a_real_in = pa2_re;
   assign a_imag_in = pa2_im;
   assign b_real_in = pb2_re;
   assign b_imag_in = pb2_im;

   // Output monitor: records every write and done pulse
   int obs_addr[512];
   int obs_re[512];
   int obs_im[512];
   int seen_re[N*N];
   int seen_im[N*N];
   int n_writes = 0;
   int n_done = 0;
   int done_cyc = 0;
   always @(negedge clk) begin
      if (wr_en && n_writes < 512) begin
         obs_addr[n_writes] = int'(wr_addr);
         obs_re[n_writes]   = int'(g_real_out);
         obs_im[n_writes]   = int'(g_imag_out);
         if (int'(wr_addr) < N*N) begin
            seen_re[int'(wr_addr)] = int'(g_real_out);
            seen_im[int'(wr_addr)] = int'(g_imag_out);
         end
         n_writes = n_writes + 1;
      end
      if (done) begin
         n_done   = n_done + 1;
         done_cyc = cyc;
      end
   end

   typedef struct { int addr; int re; int im; } wr_t;
   wr_t exp_q[$];

   typedef struct {
      string name; int pat; int lam;
      int g00_re; int g01_re; int g01_im; int g10_im;
   } vec_t;
   vec_t tbl[4];

   int n_tests = 0;
   int n_fail = 0;
   int start_cyc = 0;

   task automatic chk(input string name, input longint act, input longint expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic set_pattern(input int p);
      for (int a = 0; a < M*N; a++) begin mem_re[a] = 0; mem_im[a] = 0; end
      for (int k = 0; k < M; k++)
         for (int c = 0; c < N; c++) begin
            case (p)
               0: if (k == c) mem_re[k*N+c] = 65536;
               1: begin mem_re[k*N+c] = 65536; mem_im[k*N+c] = 65536; end
               3: mem_re[k*N+c] = 262144;
               default: ;
            endcase
         end
      if (p == 2) begin
         mem_im[0] = 65536;
         mem_re[1] = 65536;
      end
   endtask

   function automatic int sat24(input longint x);
      if (x > 64'sd8388607) return 8388607;
      if (x < -64'sd8388608) return -8388608;
      return int'(x);
   endfunction

   // Reference G from the current memory contents, pushed in expected write order
   task automatic push_expected(input int lam);
      int gr[N][N];
      int gi[N][N];
      wr_t e;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            longint sr = 0, si = 0;
            for (int k = 0; k < M; k++) begin
               longint ar = mem_re[k*N+i], ai = mem_im[k*N+i];
               longint br = mem_re[k*N+j], bi = mem_im[k*N+j];
               sr += ar*br + ai*bi;
               si += ar*bi - ai*br;
            end
            sr = sr >>> 16;
            si = si >>> 16;
            if (i == j) begin sr += lam; si = 0; end
            gr[i][j] = sat24(sr);
            gi[i][j] = sat24(si);
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
`ifdef HERM_SYM_EN
            if (j >= i) begin
               e.addr = i*N+j; e.re = gr[i][j]; e.im = gi[i][j]; exp_q.push_back(e);
               if (i != j) begin
                  e.addr = j*N+i; e.re = gr[j][i]; e.im = gi[j][i]; exp_q.push_back(e);
               end
            end
`else
            e.addr = i*N+j; e.re = gr[i][j]; e.im = gi[i][j]; exp_q.push_back(e);
`endif
         end
   endtask

   task automatic pulse_start(input int lam);
      @(posedge clk); #1;
      lambda_in = 24'(lam);
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic go_to(input int off);
      while (cyc < start_cyc + off) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input int bd);
      for (int c = 0; c < 2000; c++) begin
         if (n_done > bd) break;
         @(negedge clk);
      end
      chk("done_seen", longint'(n_done > bd), 1);
   endtask

   task automatic check_run(input string tag, input int bw, input int bd);
      wr_t e;
      repeat (4) @(negedge clk);
      chk({tag, "_done_cycle"}, done_cyc - start_cyc, EXP_DONE);
      chk({tag, "_done_count"}, n_done - bd, 1);
      chk({tag, "_write_count"}, n_writes - bw, N*N);
      for (int w = bw; w < n_writes; w++) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_write"}, obs_addr[w], -1);
         end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, obs_addr[w], e.addr);
            chk({tag, "_re"}, obs_re[w], e.re);
            chk({tag, "_im"}, obs_im[w], e.im);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_missing_write"}, -1, e.addr);
      end
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_rd_addr"}, rd_addr_a, 0);
   endtask

   initial begin
      int bw, bd, wsnap, dsnap;
      rst_n = 1'b0; start = 1'b0; lambda_in = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr_a", rd_addr_a, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_g_real", g_real_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      tbl[0] = '{"identity", 0, 16384, 81920, 0, 0, 0};
      tbl[1] = '{"all_1pj", 1, 0, 1048576, 1048576, 0, 0};
      tbl[2] = '{"conj", 2, 0, 65536, 0, -65536, 65536};
      tbl[3] = '{"saturate", 3, 0, 8388607, 8388607, 0, 0};

      for (int t = 0; t < 4; t++) begin
         set_pattern(tbl[t].pat);
         push_expected(tbl[t].lam);
         bw = n_writes; bd = n_done;
         pulse_start(tbl[t].lam);
         wait_done(bd);
         check_run(tbl[t].name, bw, bd);
         chk({tbl[t].name, "_g00_re"}, seen_re[0], tbl[t].g00_re);
         chk({tbl[t].name, "_g00_im"}, seen_im[0], 0);
         chk({tbl[t].name, "_g01_re"}, seen_re[1], tbl[t].g01_re);
         chk({tbl[t].name, "_g01_im"}, seen_im[1], tbl[t].g01_im);
         chk({tbl[t].name, "_g10_im"}, seen_im[N], tbl[t].g10_im);
      end

      // second start while busy must be ignored
      set_pattern(1);
      push_expected(0);
      bw = n_writes; bd = n_done;
      pulse_start(0);
      go_to(50);
      chk("restart_busy", busy, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(bd);
      check_run("restart", bw, bd);

      // reset mid-run aborts at once; a fresh run afterwards is complete
      set_pattern(0);
      bw = n_writes; bd = n_done;
      pulse_start(16384);
      go_to(30);
      rst_n = 1'b0;
      #1;
      chk("abort_wr_en", wr_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_writes_before", n_writes - bw, EXP_ABORT);
      wsnap = n_writes; dsnap = n_done;
      repeat (4) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_writes", n_writes - wsnap, 0);
      chk("abort_no_done", n_done - dsnap, 0);
      set_pattern(2);
      push_expected(0);
      bw = n_writes; bd = n_done;
      pulse_start(0);
      wait_done(bd);
      check_run("after_reset", bw, bd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
